// File: rtl/uart_wb_master_pkg.sv
// Shared types and protocol byte values for the UART-to-Wishbone debug bridge.
package uart_wb_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

endpackage

// File: rtl/uart_byte_io.sv
// 8N1 byte receiver and transmitter sharing one bit-period divider setting.
module uart_byte_io
    import uart_wb_master_pkg::*;
#(
    parameter logic [31:0] CLK_DIV = 32'd1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ser_rx,
    output logic       ser_tx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy
);

    localparam logic [31:0] HALF    = (CLK_DIV + 32'd1) >> 1;
    localparam logic [31:0] HALF_M1 = (HALF == 32'd0) ? 32'd0 : HALF - 32'd1;

    rx_state_t   rx_st, rx_nxt;
    logic        rx_meta, rx_s;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bits;
    logic [7:0]  rx_sh;
    logic        rx_tick;

    assign rx_data = rx_sh;
    assign rx_tick = (rx_cnt == ((rx_st == RX_START) ? HALF_M1 : CLK_DIV));

    always_comb begin
        rx_nxt = rx_st;
        case (rx_st)
            RX_IDLE:  if (!rx_s) rx_nxt = RX_START;
            RX_START: if (rx_tick) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bits == 3'd7) rx_nxt = RX_STOP;
            RX_STOP:  if (rx_tick) rx_nxt = RX_IDLE;
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_st    <= RX_IDLE;
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_st    <= rx_nxt;
            rx_meta  <= ser_rx;
            rx_s     <= rx_meta;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_cnt   <= (rx_st == RX_IDLE || rx_tick) ? 32'd0 : rx_cnt + 32'd1;
            if (rx_st == RX_START)
                rx_bits <= '0;
            else if (rx_st == RX_DATA && rx_tick) begin
                rx_bits <= rx_bits + 3'd1;
                rx_sh   <= {rx_s, rx_sh[7:1]};
            end
            if (rx_st == RX_STOP && rx_tick) begin
                rx_valid <= rx_s;
                rx_ferr  <= !rx_s;
            end
        end
    end

    // tx_busy drops in the final stop-bit cycle so a queued byte starts with no gap.
    logic        tx_act;
    logic [31:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [8:0]  tx_sh;
    logic        tx_load;

    assign tx_busy = tx_act && !(tx_bit == 4'd9 && tx_cnt == CLK_DIV);
    assign tx_load = tx_start && !tx_busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ser_tx <= 1'b1;
            tx_act <= 1'b0;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '1;
        end else if (tx_load) begin
            ser_tx <= 1'b0;
            tx_act <= 1'b1;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= {1'b1, tx_data};
        end else if (tx_act) begin
            if (tx_cnt == CLK_DIV) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9)
                    tx_act <= 1'b0;
                else begin
                    ser_tx <= tx_sh[0];
                    tx_sh  <= {1'b1, tx_sh[8:1]};
                    tx_bit <= tx_bit + 4'd1;
                end
            end else
                tx_cnt <= tx_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/uart_wb_master.sv
// Serial command decoder that issues single 32-bit Wishbone master cycles and reports ACK/NAK.
module uart_wb_master
    import uart_wb_master_pkg::*;
#(
    parameter logic [31:0] CLK_DIV = 32'd1,
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic        wb_clk_i,
    input  logic        resetn,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);

    state_t      state, nxt;
    logic        rx_valid, rx_ferr, tx_start, tx_busy;
    logic [7:0]  rx_data, tx_byte;
    logic [1:0]  byte_cnt;
    logic [31:0] adr_sh;
    logic [23:0] dat_sh;
    logic [31:0] rdata;
    logic        is_wr, nak;
    logic [2:0]  resp_idx, resp_len;
    logic [15:0] to_cnt;
    logic        timed_out, bus_go, bus_end;

    uart_byte_io #(.CLK_DIV(CLK_DIV)) u_io (
        .clk      (wb_clk_i),
        .resetn   (resetn),
        .ser_rx   (ser_rx),
        .ser_tx   (ser_tx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr),
        .tx_start (tx_start),
        .tx_data  (tx_byte),
        .tx_busy  (tx_busy)
    );

    assign busy      = (state != IDLE);
    assign wbm_stb_o = wbm_cyc_o;
    assign timed_out = ({1'b0, to_cnt} + 17'd1) >= {1'b0, TIMEOUT};
    assign resp_len  = (nak || is_wr) ? 3'd1 : 3'd5;

    always_comb begin
        case (resp_idx)
            3'd0:    tx_byte = nak ? RSP_NAK : RSP_ACK;
            3'd1:    tx_byte = rdata[31:24];
            3'd2:    tx_byte = rdata[23:16];
            3'd3:    tx_byte = rdata[15:8];
            3'd4:    tx_byte = rdata[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        nxt      = state;
        tx_start = 1'b0;
        bus_go   = 1'b0;
        bus_end  = 1'b0;
        case (state)
            IDLE:
                if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ))
                    nxt = GET_ADDR;
            GET_ADDR:
                if (rx_ferr)
                    nxt = IDLE;
                else if (rx_valid && byte_cnt == 2'd3) begin
                    nxt    = is_wr ? GET_DATA : BUS;
                    bus_go = !is_wr;
                end
            GET_DATA:
                if (rx_ferr)
                    nxt = IDLE;
                else if (rx_valid && byte_cnt == 2'd3) begin
                    nxt    = BUS;
                    bus_go = 1'b1;
                end
            BUS:
                if (wbm_ack_i || timed_out) begin
                    nxt     = RESP;
                    bus_end = 1'b1;
                end
            RESP:
                if (!tx_busy) begin
                    if (resp_idx < resp_len)
                        tx_start = 1'b1;
                    else
                        nxt = IDLE;
                end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            byte_cnt  <= '0;
            adr_sh    <= '0;
            dat_sh    <= '0;
            is_wr     <= 1'b0;
            nak       <= 1'b0;
            rdata     <= '0;
            resp_idx  <= '0;
            to_cnt    <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
        end else begin
            if (state == IDLE && nxt == GET_ADDR) begin
                is_wr    <= (rx_data == CMD_WRITE);
                byte_cnt <= '0;
            end
            if (rx_valid && state == GET_ADDR) begin
                adr_sh   <= {adr_sh[23:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (rx_valid && state == GET_DATA) begin
                dat_sh   <= {dat_sh[15:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            // Final byte is still on rx_data, so splice it in directly.
            if (bus_go) begin
                wbm_cyc_o <= 1'b1;
                wbm_we_o  <= is_wr;
                wbm_sel_o <= 4'hF;
                to_cnt    <= '0;
                if (state == GET_ADDR)
                    wbm_adr_o <= {adr_sh[23:0], rx_data};
                else begin
                    wbm_adr_o <= adr_sh;
                    wbm_dat_o <= {dat_sh, rx_data};
                end
            end else if (state == BUS)
                to_cnt <= to_cnt + 16'd1;
            if (bus_end) begin
                wbm_cyc_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                wbm_sel_o <= '0;
                nak       <= !wbm_ack_i;
                rdata     <= wbm_dat_i;
                resp_idx  <= '0;
            end
            if (tx_start)
                resp_idx <= resp_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for the UART-to-Wishbone bridge: host frames in, bus cycles and responses checked.
module tb_uart_wb_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ser_rx;
    logic        ser_tx;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, busy;

    int n_pass = 0;
    int n_total = 0;
    int cyc_n = 0;

    // slave model state
    logic        slave_en = 1'b1;
    int          ack_lat = 0;
    int          st_cnt = 0;
    int          n_bus = 0;
    int          stb_cycles = 0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;

    // response monitor
    logic [7:0] rxq[$];
    int         rxt[$];

    uart_wb_master #(.CLK_DIV(32'd3), .TIMEOUT(16'd16)) dut (
        .wb_clk_i  (clk),
        .resetn    (resetn),
        .ser_rx    (ser_rx),
        .ser_tx    (ser_tx),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (!resetn) begin
            wbm_ack_i = 1'b0;
            st_cnt = 0;
        end else if (wbm_stb_o) begin
            if (st_cnt == 0) begin
                n_bus++;
                cap_adr = wbm_adr_o;
                cap_dat = wbm_dat_o;
                cap_we  = wbm_we_o;
                cap_sel = wbm_sel_o;
            end
            stb_cycles++;
            wbm_ack_i = slave_en && (st_cnt == ack_lat);
            st_cnt++;
        end else begin
            wbm_ack_i = 1'b0;
            st_cnt = 0;
        end
    end

    initial begin
        logic [7:0] b;
        int t;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && ser_tx === 1'b0) begin
                t = cyc_n;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = ser_tx;
                end
                repeat (4) @(negedge clk);
                if (ser_tx === 1'b1) begin
                    rxq.push_back(b);
                    rxt.push_back(t);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] v, input logic stop_bit);
        ser_rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = v[i];
            repeat (4) @(negedge clk);
        end
        ser_rx = stop_bit;
        repeat (4) @(negedge clk);
        ser_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [71:0] bytes, input int n);
        for (int i = 0; i < n; i++)
            send_byte(bytes[8*(n-1-i) +: 8], 1'b1);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (rxq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic clear_mon();
        rxq.delete();
        rxt.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ser_rx = 1'b1;
        wbm_dat_i = 32'h0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({ser_tx, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy} !== 5'b10000)
            $display("FAIL reset_ctrl got tx/cyc/stb/we/busy=%b want 10000",
                     {ser_tx, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy});
        else n_pass++;
        n_total++;
        if (wbm_sel_o !== 4'h0) $display("FAIL reset_sel got %h want 0", wbm_sel_o);
        else n_pass++;
        n_total++;
        if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0)
            $display("FAIL reset_adr_dat got %h/%h want 0/0", wbm_adr_o, wbm_dat_o);
        else n_pass++;
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || ser_tx !== 1'b1)
            $display("FAIL reset_release got busy=%b tx=%b want 0/1", busy, ser_tx);
        else n_pass++;
    endtask

    task automatic test_write();
        int nb0, k, last_t;
        nb0 = n_bus; stb_cycles = 0; slave_en = 1'b1; ack_lat = 2;
        clear_mon();
        send_frame(72'h01_20000004_00000041, 9);
        wait_bytes(1, 400);
        n_total++;
        if (n_bus - nb0 != 1 || cap_adr !== 32'h20000004 || cap_dat !== 32'h41)
            $display("FAIL write_bus got n=%0d adr=%h dat=%h want 1/20000004/00000041",
                     n_bus - nb0, cap_adr, cap_dat);
        else n_pass++;
        n_total++;
        if (cap_we !== 1'b1 || cap_sel !== 4'hF)
            $display("FAIL write_we_sel got we=%b sel=%h want 1/f", cap_we, cap_sel);
        else n_pass++;
        n_total++;
        if (stb_cycles != 3) $display("FAIL write_stb_len got %0d want 3", stb_cycles);
        else n_pass++;
        k = 0;
        while (busy === 1'b1 && k < 100) begin @(negedge clk); k++; end
        last_t = (rxt.size() > 0) ? rxt[rxt.size()-1] : -1000;
        n_total++;
        if (busy !== 1'b0 || cyc_n - last_t != 40)
            $display("FAIL write_busy_fall got busy=%b delay=%0d want 0/40", busy, cyc_n - last_t);
        else n_pass++;
        repeat (50) @(negedge clk);
        n_total++;
        if (rxq.size() != 1 || rxq[0] !== 8'h06)
            $display("FAIL write_resp got n=%0d first=%h want 1/06", rxq.size(),
                     (rxq.size() > 0) ? rxq[0] : 8'hxx);
        else n_pass++;
        n_total++;
        if (wbm_adr_o !== 32'h20000004 || wbm_dat_o !== 32'h41 || wbm_cyc_o !== 1'b0 || wbm_sel_o !== 4'h0)
            $display("FAIL write_hold got adr=%h dat=%h cyc=%b sel=%h want 20000004/00000041/0/0",
                     wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_sel_o);
        else n_pass++;
    endtask

    task automatic test_read_b2b();
        logic [39:0] got;
        int gaps_ok;
        stb_cycles = 0; slave_en = 1'b1; ack_lat = 0; wbm_dat_i = 32'h00000001;
        clear_mon();
        send_frame(72'h02_20000000, 5);
        wait_bytes(5, 400);
        got = '0;
        for (int i = 0; i < 5 && i < rxq.size(); i++) got = {got[31:0], rxq[i]};
        n_total++;
        if (rxq.size() != 5 || got !== 40'h06_00000001)
            $display("FAIL read_resp got n=%0d bytes=%h want 5/0600000001", rxq.size(), got);
        else n_pass++;
        gaps_ok = 0;
        for (int i = 1; i < rxt.size(); i++) if (rxt[i] - rxt[i-1] == 40) gaps_ok++;
        n_total++;
        if (gaps_ok != 4) $display("FAIL read_back_to_back got %0d gaps of 40 want 4", gaps_ok);
        else n_pass++;
        n_total++;
        if (cap_we !== 1'b0 || cap_adr !== 32'h20000000 || stb_cycles != 1)
            $display("FAIL read_bus got we=%b adr=%h stb=%0d want 0/20000000/1", cap_we, cap_adr, stb_cycles);
        else n_pass++;
        n_total++;
        if (wbm_dat_o !== 32'h41) $display("FAIL read_dat_hold got %h want 00000041", wbm_dat_o);
        else n_pass++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_timeout();
        int nb0;
        nb0 = n_bus; stb_cycles = 0; slave_en = 1'b0;
        clear_mon();
        send_frame(72'h02_30000000, 5);
        wait_bytes(1, 600);
        repeat (100) @(negedge clk);
        n_total++;
        if (stb_cycles != 16) $display("FAIL timeout_stb_len got %0d want 16", stb_cycles);
        else n_pass++;
        n_total++;
        if (rxq.size() != 1 || rxq[0] !== 8'h15)
            $display("FAIL timeout_resp got n=%0d first=%h want 1/15", rxq.size(),
                     (rxq.size() > 0) ? rxq[0] : 8'hxx);
        else n_pass++;
        n_total++;
        if (n_bus - nb0 != 1 || busy !== 1'b0)
            $display("FAIL timeout_quiet got cycles=%0d busy=%b want 1/0", n_bus - nb0, busy);
        else n_pass++;
        slave_en = 1'b1;
    endtask

    task automatic test_bad_cmd();
        int nb0;
        logic [39:0] got;
        nb0 = n_bus; slave_en = 1'b1; ack_lat = 1; wbm_dat_i = 32'hDEADBEEF;
        clear_mon();
        send_byte(8'h7E, 1'b1);
        repeat (60) @(negedge clk);
        n_total++;
        if (rxq.size() != 0 || n_bus != nb0 || busy !== 1'b0)
            $display("FAIL badcmd_ignored got resp=%0d cycles=%0d busy=%b want 0/0/0",
                     rxq.size(), n_bus - nb0, busy);
        else n_pass++;
        send_frame(72'h02_20000008, 5);
        wait_bytes(5, 400);
        got = '0;
        for (int i = 0; i < 5 && i < rxq.size(); i++) got = {got[31:0], rxq[i]};
        n_total++;
        if (got !== 40'h06_DEADBEEF || cap_adr !== 32'h20000008)
            $display("FAIL badcmd_then_read got bytes=%h adr=%h want 06deadbeef/20000008", got, cap_adr);
        else n_pass++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_ferr();
        int nb0;
        nb0 = n_bus; slave_en = 1'b1; ack_lat = 0;
        clear_mon();
        send_byte(8'h01, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (80) @(negedge clk);
        n_total++;
        if (n_bus != nb0 || busy !== 1'b0 || rxq.size() != 0)
            $display("FAIL ferr_abort got cycles=%0d busy=%b resp=%0d want 0/0/0",
                     n_bus - nb0, busy, rxq.size());
        else n_pass++;
        send_frame(72'h01_2000000C_12345678, 9);
        wait_bytes(1, 400);
        n_total++;
        if (n_bus - nb0 != 1 || cap_adr !== 32'h2000000C || cap_dat !== 32'h12345678 || cap_we !== 1'b1)
            $display("FAIL ferr_recover got n=%0d adr=%h dat=%h we=%b want 1/2000000c/12345678/1",
                     n_bus - nb0, cap_adr, cap_dat, cap_we);
        else n_pass++;
        n_total++;
        if (rxq.size() < 1 || rxq[0] !== 8'h06)
            $display("FAIL ferr_recover_resp got n=%0d want ack 06", rxq.size());
        else n_pass++;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k, nb0;
        slave_en = 1'b0;
        clear_mon();
        send_frame(72'h02_40000000, 5);
        k = 0;
        while (wbm_stb_o !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        n_total++;
        if (wbm_stb_o !== 1'b1) $display("FAIL rstmid_stb_seen got stb=%b want 1", wbm_stb_o);
        else n_pass++;
        resetn = 1'b0;
        #1;
        n_total++;
        if ({wbm_cyc_o, wbm_stb_o, ser_tx} !== 3'b001 || wbm_adr_o !== 32'h0)
            $display("FAIL rstmid_bus got cyc/stb/tx=%b adr=%h want 001/0",
                     {wbm_cyc_o, wbm_stb_o, ser_tx}, wbm_adr_o);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        slave_en = 1'b1; ack_lat = 0; wbm_dat_i = 32'h0;
        repeat (10) @(negedge clk);
        send_frame(72'h02_40000000, 5);
        k = 0;
        while (ser_tx !== 1'b0 && k < 300) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        n_total++;
        if (ser_tx !== 1'b0 || busy !== 1'b1)
            $display("FAIL rstmid_tx_active got tx=%b busy=%b want 0/1", ser_tx, busy);
        else n_pass++;
        resetn = 1'b0;
        #1;
        n_total++;
        if ({wbm_cyc_o, wbm_stb_o, ser_tx, busy} !== 4'b0010)
            $display("FAIL rstmid_tx got cyc/stb/tx/busy=%b want 0010",
                     {wbm_cyc_o, wbm_stb_o, ser_tx, busy});
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        repeat (60) @(negedge clk);
        clear_mon();
        nb0 = n_bus; stb_cycles = 0; ack_lat = 1;
        send_frame(72'h01_50000010_CAFEF00D, 9);
        wait_bytes(1, 400);
        n_total++;
        if (n_bus - nb0 != 1 || cap_adr !== 32'h50000010 || cap_dat !== 32'hCAFEF00D || stb_cycles != 2)
            $display("FAIL rstmid_recover got n=%0d adr=%h dat=%h stb=%0d want 1/50000010/cafef00d/2",
                     n_bus - nb0, cap_adr, cap_dat, stb_cycles);
        else n_pass++;
        n_total++;
        if (rxq.size() < 1 || rxq[0] !== 8'h06)
            $display("FAIL rstmid_recover_resp got n=%0d want ack 06", rxq.size());
        else n_pass++;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_b2b();
        test_timeout();
        test_bad_cmd();
        test_ferr();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
